// File: rtl/report_collector_c1.sv
// report_collector_c1: collects per-automaton report bits into a pending set,
// round-robin arbitrates among them and emits one report per handshake on a
// single valid/ready stream. Drains at end of stream and counts dropped hits.
// Optional feature macro: REPORT_TIMESTAMP_EN (per-hit symbol-cycle timestamps).
module report_collector_c1 #(
    parameter int unsigned NUM_REPORTS = 36,
    parameter int unsigned ID_W        = 6,
    parameter int unsigned TS_W        = 16,
    parameter int unsigned OVF_W       = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_run,
    input  logic [NUM_REPORTS-1:0] i_report_in,
    input  logic                   i_eos,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [ID_W-1:0]        o_out_id,
    output logic [TS_W-1:0]        o_out_ts,
    output logic                   o_drain_done,
    output logic [OVF_W-1:0]       o_ovf_count
);

    typedef enum logic [1:0] {StIdle, StActive, StDrain, StDone} state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [NUM_REPORTS-1:0] r_pending;
    logic [NUM_REPORTS-1:0] w_pending_next;
    logic [NUM_REPORTS-1:0] w_set;
    logic [NUM_REPORTS-1:0] w_clear;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [ID_W-1:0]        r_out_id;
    logic [ID_W-1:0]        w_grant_id;
    logic                   r_out_valid;
    logic                   w_grant_valid;
    logic                   w_can_load;
    logic                   w_grant_fire;
    logic                   w_sample;
    logic                   w_collision;
    logic [OVF_W-1:0]       r_ovf_count;

    // Hits are only taken while not draining; the eos cycle itself still samples.
    assign w_sample       = i_run && ((r_state == StIdle) || (r_state == StActive));
    assign w_set          = w_sample ? i_report_in : '0;
    assign w_can_load     = !r_out_valid || i_out_ready;
    assign w_grant_fire   = w_grant_valid && w_can_load;
    // A bit granted this cycle frees its slot, so a same-cycle re-set is not a drop.
    assign w_collision    = |(w_set & r_pending & ~w_clear);
    assign w_pending_next = (r_pending & ~w_clear) | w_set;

    // Round-robin search: first pending index at or above the pointer, wrapping.
    always_comb begin
        logic [ID_W:0]   v_sum;
        logic [ID_W-1:0] v_idx;
        w_grant_valid = 1'b0;
        w_grant_id    = '0;
        v_sum         = '0;
        v_idx         = '0;
        for (int k = 0; k < int'(NUM_REPORTS); k++) begin
            v_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (v_sum >= (ID_W+1)'(NUM_REPORTS)) begin
                v_sum = v_sum - (ID_W+1)'(NUM_REPORTS);
            end
            v_idx = v_sum[ID_W-1:0];
            if (!w_grant_valid && r_pending[v_idx]) begin
                w_grant_valid = 1'b1;
                w_grant_id    = v_idx;
            end
        end
    end

    // One-hot clear mask for the granted bit.
    always_comb begin
        w_clear = '0;
        if (w_grant_fire) begin
            w_clear[w_grant_id] = 1'b1;
        end
    end

    // Next-state logic for the collection / drain sequence.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_eos) begin
                    w_state_next = StDrain;
                end else if (i_run && (|i_report_in)) begin
                    w_state_next = StActive;
                end
            end
            StActive: begin
                if (i_eos) begin
                    w_state_next = StDrain;
                end else if ((r_pending == '0) && !r_out_valid) begin
                    w_state_next = StIdle;
                end
            end
            StDrain: begin
                if ((r_pending == '0) && !r_out_valid) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State, pending set, arbitration pointer, output register and drop counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_pending   <= '0;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_ovf_count <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            if (w_collision && (r_ovf_count != '1)) begin
                r_ovf_count <= r_ovf_count + OVF_W'(1);
            end
            if (w_can_load) begin
                r_out_valid <= w_grant_valid;
            end
            if (w_grant_fire) begin
                r_out_id <= w_grant_id;
                r_rr_ptr <= (w_grant_id == ID_W'(NUM_REPORTS - 1)) ? '0
                                                                   : w_grant_id + ID_W'(1);
            end
        end
    end

`ifdef REPORT_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts_cnt;
    logic [TS_W-1:0] r_ts_mem [NUM_REPORTS];
    logic [TS_W-1:0] r_out_ts;

    // Symbol-cycle counter and per-bit timestamp capture; a re-set overwrites.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ts_cnt <= '0;
            r_out_ts <= '0;
            for (int i = 0; i < int'(NUM_REPORTS); i++) begin
                r_ts_mem[i] <= '0;
            end
        end else begin
            if (i_run) begin
                r_ts_cnt <= r_ts_cnt + TS_W'(1);
            end
            if (w_grant_fire) begin
                r_out_ts <= r_ts_mem[w_grant_id];
            end
            for (int i = 0; i < int'(NUM_REPORTS); i++) begin
                if (w_set[i]) begin
                    r_ts_mem[i] <= r_ts_cnt;
                end
            end
        end
    end

    assign o_out_ts = r_out_ts;
`else
    assign o_out_ts = '0;
`endif

    assign o_out_valid  = r_out_valid;
    assign o_out_id     = r_out_id;
    assign o_drain_done = (r_state == StDone);
    assign o_ovf_count  = r_ovf_count;

endmodule

// File: tb/tb_report_collector_c1.sv
// Bench for report_collector_c1: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the report stream.
module tb_report_collector_c1;

    localparam int N = 36;

    logic         clk;
    logic         reset;
    logic         run;
    logic [N-1:0] rep;
    logic         eos;
    logic         ready;
    logic         o_valid;
    logic [5:0]   o_id;
    logic [15:0]  o_ts;
    logic         o_done;
    logic [7:0]   o_ovf;

    report_collector_c1 dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_run       (run),
        .i_report_in (rep),
        .i_eos       (eos),
        .o_out_valid (o_valid),
        .i_out_ready (ready),
        .o_out_id    (o_id),
        .o_out_ts    (o_ts),
        .o_drain_done(o_done),
        .o_ovf_count (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: set of pending ids, pointer, one output slot, drain phase.
    bit          m_pend [N];
    int unsigned m_tsv  [N];
    int          m_rr;
    bit          m_ov;
    int          m_id;
    int unsigned m_ots;
    int          m_ovf;
    bit          m_drain;
    bit          m_done;
    int unsigned m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_tsv[i]  = 0;
        end
        m_rr = 0; m_ov = 0; m_id = 0; m_ots = 0; m_ovf = 0;
        m_drain = 0; m_done = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit r, input logic [N-1:0] rp, input bit e, input bit rd);
        bit can_load, found, sample, coll, pend_empty, old_ov;
        int g;
        can_load   = !m_ov || rd;
        sample     = r && !m_drain && !m_done;
        found      = 0;
        g          = 0;
        pend_empty = 1;
        old_ov     = m_ov;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (!found && m_pend[idx]) begin
                found = 1;
                g     = idx;
            end
            if (m_pend[k]) pend_empty = 0;
        end
        if (m_done) m_done = 0;
        else if (m_drain) begin
            if (pend_empty && !old_ov) begin
                m_drain = 0;
                m_done  = 1;
            end
        end else if (e) m_drain = 1;
        if (can_load) begin
            m_ov = found;
            if (found) begin
                m_id      = g;
                m_ots     = m_tsv[g];
                m_pend[g] = 0;
                m_rr      = (g + 1) % N;
            end
        end
        coll = 0;
        if (sample) begin
            for (int i = 0; i < N; i++) begin
                if (rp[i]) begin
                    if (m_pend[i]) coll = 1;
                    m_pend[i] = 1;
                    m_tsv[i]  = m_cnt;
                end
            end
        end
        if (coll && m_ovf < 255) m_ovf++;
        if (r) m_cnt = (m_cnt + 1) % 65536;
    endtask

    function automatic int unsigned exp_ts();
`ifdef REPORT_TIMESTAMP_EN
        return m_ots;
`else
        return 0;
`endif
    endfunction

    task automatic compare_all();
        chk("valid", 32'(o_valid), 32'(m_ov));
        chk("id", 32'(o_id), 32'(m_id));
        chk("drain_done", 32'(o_done), 32'(m_done));
        chk("ovf", 32'(o_ovf), 32'(m_ovf));
        chk("ts", 32'(o_ts), exp_ts());
    endtask

    task automatic step(input bit r, input logic [N-1:0] rp, input bit e, input bit rd);
        @(negedge clk);
        run = r; rep = rp; eos = e; ready = rd;
        model_step(r, rp, e, rd);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; run = 1'b0; rep = '0; eos = 1'b0; ready = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        compare_all();
    endtask

    initial begin
        int          reports;
        int          pulses;
        logic [63:0] w0;
        logic [63:0] w1;
        logic [N-1:0] rb;
        reset = 1'b1; run = 1'b0; rep = '0; eos = 1'b0; ready = 1'b0;

        // Single hit: reported two cycles later, for one cycle.
        do_reset();
        step(1, oh(5), 0, 1);
        step(0, '0, 0, 1);
        chk("t1_valid", 32'(o_valid), 1);
        chk("t1_id", 32'(o_id), 5);
        step(0, '0, 0, 1);
        chk("t1_valid_gone", 32'(o_valid), 0);
        chk("t1_ovf", 32'(o_ovf), 0);

        // Three ids back to back, pointer wraps past 35 to 0.
        do_reset();
        step(1, oh(0) | oh(17) | oh(35), 0, 1);
        step(0, '0, 0, 1);
        chk("t2_id0", 32'(o_id), 0);
        step(0, '0, 0, 1);
        chk("t2_id17", 32'(o_id), 17);
        step(0, '0, 0, 1);
        chk("t2_id35", 32'(o_id), 35);
        step(1, oh(0) | oh(20), 0, 1);
        step(0, '0, 0, 1);
        chk("t2_wrap_id0", 32'(o_id), 0);
        step(0, '0, 0, 1);
        chk("t2_id20", 32'(o_id), 20);

        // Stalled output: repeated hits on bit 3 collide twice.
        do_reset();
        step(1, oh(7), 0, 0);
        step(0, '0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, oh(3), 0, 0);
        chk("t3_ovf", 32'(o_ovf), 2);
        chk("t3_stall_id", 32'(o_id), 7);
        step(0, '0, 0, 1);
        chk("t3_id3", 32'(o_id), 3);
        step(0, '0, 0, 1);
        chk("t3_single", 32'(o_valid), 0);

        // Saturation of the drop counter.
        do_reset();
        step(1, oh(7), 0, 0);
        step(0, '0, 0, 0);
        for (int i = 0; i < 261; i++) step(1, oh(3), 0, 0);
        chk("t4_sat", 32'(o_ovf), 255);

        // Drain: four pending reports, then exactly one drain_done pulse.
        do_reset();
        step(1, oh(2) | oh(9) | oh(20) | oh(30), 0, 0);
        step(0, '0, 1, 0);
        reports = o_valid ? 1 : 0;
        pulses  = 0;
        for (int i = 0; i < 12; i++) begin
            w0 = {$urandom, $urandom};
            rb = (pulses == 0) ? w0[N-1:0] : '0;
            step(1, rb, 0, 1);
            if (pulses == 0 && o_valid) reports++;
            if (o_done) pulses++;
        end
        chk("t5_reports", 32'(reports), 4);
        chk("t5_pulses", 32'(pulses), 1);
        step(1, oh(11), 0, 1);
        step(0, '0, 0, 1);
        chk("t5_idle_valid", 32'(o_valid), 1);
        chk("t5_idle_id", 32'(o_id), 11);

        // Timestamp of a hit on the 10th run cycle, then reset during drain.
        do_reset();
        for (int i = 0; i < 9; i++) step(1, '0, 0, 1);
        step(1, oh(4), 0, 1);
        step(0, '0, 0, 1);
        chk("t6_id", 32'(o_id), 4);
`ifdef REPORT_TIMESTAMP_EN
        chk("t6_ts", 32'(o_ts), 9);
`else
        chk("t6_ts", 32'(o_ts), 0);
`endif
        step(1, oh(1) | oh(2) | oh(3), 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        chk("t6_pre_valid", 32'(o_valid), 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6_async_valid", 32'(o_valid), 0);
        chk("t6_async_id", 32'(o_id), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(0, '0, 0, 1);
            chk("t6_no_done", 32'(o_done), 0);
        end

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            w0 = {$urandom, $urandom};
            w1 = {$urandom, $urandom};
            rb = ($urandom_range(0, 2) == 0) ? (w0[N-1:0] & w1[N-1:0]) : '0;
            step($urandom_range(0, 3) != 0, rb, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
